eq_coeff_bank: RTL and testbench

//  Coefficient store that answers the equalizer's coefficient read port (eq_coeff_addr -> eq_coeff).

---
 rtl/eq_coeff_bank.sv | 161 ++++++++++++++++
 tb/tb_eq_coeff_bank.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/eq_coeff_bank.sv
// Double-buffered equalizer coefficient store: host writes land in the shadow bank,
// a commit swaps banks on the next frame boundary and the new active set is copied back.
module eq_coeff_bank #(
  parameter  int NR_CHANNELS    = 3,
  parameter  int NR_EQ_BANDS    = 8,
  parameter  int EQ_COEFF_WIDTH = 32,
  localparam int NR_EQ_COEFF    = NR_CHANNELS * NR_EQ_BANDS * 5,
  localparam int ADDR_W         = $clog2(NR_EQ_COEFF)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         eq_coeff_addr,
  output logic [EQ_COEFF_WIDTH-1:0] eq_coeff,
  input  logic                      frame_sync,
  input  logic [EQ_COEFF_WIDTH-1:0] s_wr_d,
  input  logic [ADDR_W-1:0]         s_wr_addr,
  input  logic                      s_wr_dv,
  output logic                      s_wr_dr,
  input  logic                      commit,
  output logic                      busy,
  output logic                      bank_sel,
  output logic                      wr_err
);

  // state   | meaning
  // INIT    | fill both banks with the unity pattern, one word per clock
  // IDLE    | accept host writes into the shadow bank, wait for commit
  // PENDING | commit seen, wait for frame_sync to swap banks
  // COPY    | copy the new active bank into the shadow, one word per clock
  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PENDING = 2'd2,
    ST_COPY    = 2'd3
  } state_t;

  localparam logic [EQ_COEFF_WIDTH-1:0] UNITY = EQ_COEFF_WIDTH'(1) << (EQ_COEFF_WIDTH - 4);
  localparam logic [ADDR_W-1:0]         LAST  = ADDR_W'(NR_EQ_COEFF - 1);

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           cnt_q, cnt_d;
  logic                        bank_sel_q, bank_sel_d;
  logic                        wr_err_q, wr_err_d;
  logic [EQ_COEFF_WIDTH-1:0]   eq_coeff_q, eq_coeff_d;

  logic [EQ_COEFF_WIDTH-1:0]   bank_q [2][NR_EQ_COEFF];
  logic [1:0]                  mem_we;
  logic [ADDR_W-1:0]           mem_waddr;
  logic [EQ_COEFF_WIDTH-1:0]   mem_wdata;

  logic                        wr_fire;
  logic                        wr_addr_ok;

  function automatic logic [EQ_COEFF_WIDTH-1:0] unity_word(input logic [ADDR_W-1:0] a);
    return ((int'(a) % 5) == 0) ? UNITY : '0;
  endfunction

  assign wr_fire    = (state_q == ST_IDLE) && s_wr_dv;
  assign wr_addr_ok = (s_wr_addr <= LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      bank_sel_q <= 1'b0;
      wr_err_q   <= 1'b0;
      eq_coeff_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bank_sel_q <= bank_sel_d;
      wr_err_q   <= wr_err_d;
      eq_coeff_q <= eq_coeff_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bank_sel_d = bank_sel_q;
    wr_err_d   = wr_err_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // a bad write in the commit cycle belongs to the committed set, so it survives the clear
        if (commit) begin
          state_d  = ST_PENDING;
          wr_err_d = wr_fire && !wr_addr_ok;
        end else if (wr_fire && !wr_addr_ok) begin
          wr_err_d = 1'b1;
        end
      end
      ST_PENDING: begin
        if (frame_sync) begin
          bank_sel_d = ~bank_sel_q;
          cnt_d      = '0;
          state_d    = ST_COPY;
        end
      end
      ST_COPY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    mem_we    = 2'b00;
    mem_waddr = cnt_q;
    mem_wdata = '0;
    case (state_q)
      ST_INIT: begin
        mem_we    = 2'b11;
        mem_wdata = unity_word(cnt_q);
      end
      ST_IDLE: begin
        if (wr_fire && wr_addr_ok) begin
          mem_we    = bank_sel_q ? 2'b01 : 2'b10;
          mem_waddr = s_wr_addr;
          mem_wdata = s_wr_d;
        end
      end
      ST_COPY: begin
        mem_we    = bank_sel_q ? 2'b01 : 2'b10;
        mem_wdata = bank_q[bank_sel_q][cnt_q];
      end
      default: ;
    endcase

    if (eq_coeff_addr > LAST)
      eq_coeff_d = '0;
    else if (state_q == ST_INIT)
      eq_coeff_d = unity_word(eq_coeff_addr);
    else
      eq_coeff_d = bank_q[bank_sel_q][eq_coeff_addr];
  end

  // storage is not reset: INIT rewrites every word after any reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (mem_we[b]) bank_q[b][mem_waddr] <= mem_wdata;
    end
  end

  assign eq_coeff = eq_coeff_q;
  assign s_wr_dr  = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign bank_sel = bank_sel_q;
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_eq_coeff_bank.sv
// Randomized bench for eq_coeff_bank against a bank-level model of the double buffer.
module tb_eq_coeff_bank;
  localparam int N = 120;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  eq_coeff_addr = '0;
  logic [31:0] eq_coeff;
  logic        frame_sync = 1'b0;
  logic [31:0] s_wr_d = '0;
  logic [6:0]  s_wr_addr = '0;
  logic        s_wr_dv = 1'b0;
  logic        s_wr_dr;
  logic        commit = 1'b0;
  logic        busy;
  logic        bank_sel;
  logic        wr_err;

  int n_chk = 0;
  int n_bad = 0;

  logic [31:0] m_act [N];
  logic [31:0] m_shd [N];
  logic        m_sel;
  logic        m_err;
  logic        m_pend;

  eq_coeff_bank dut (
    .clk(clk), .rst_n(rst_n), .eq_coeff_addr(eq_coeff_addr), .eq_coeff(eq_coeff),
    .frame_sync(frame_sync), .s_wr_d(s_wr_d), .s_wr_addr(s_wr_addr), .s_wr_dv(s_wr_dv),
    .s_wr_dr(s_wr_dr), .commit(commit), .busy(busy), .bank_sel(bank_sel), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] unity(input int a);
    return (a < N && (a % 5) == 0) ? 32'h1000_0000 : 32'h0;
  endfunction

  function automatic logic [31:0] exp_read(input logic [6:0] a);
    return (int'(a) < N) ? m_act[int'(a)] : 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = unity(i);
      m_shd[i] = unity(i);
    end
    m_sel = 1'b0; m_err = 1'b0; m_pend = 1'b0;
  endtask

  task automatic read_chk(input logic [6:0] a);
    eq_coeff_addr = a;
    step();
    check("read", eq_coeff, exp_read(a));
  endtask

  task automatic do_write(input logic [6:0] a, input logic [31:0] d);
    int n;
    s_wr_addr = a; s_wr_d = d; s_wr_dv = 1'b1;
    n = 0;
    while (!s_wr_dr && n < 400) begin step(); n++; end
    if (n >= 400) check("wr_ready_timeout", 32'(n), 32'd0);
    step();
    s_wr_dv = 1'b0;
    if (int'(a) < N) m_shd[int'(a)] = d;
    else m_err = 1'b1;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
    if (!m_pend) begin m_pend = 1'b1; m_err = 1'b0; end
  endtask

  task automatic do_swap();
    logic [31:0] exp_old;
    exp_old = exp_read(eq_coeff_addr);
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    check("swap_edge_read", eq_coeff, exp_old);
    if (m_pend) begin
      for (int i = 0; i < N; i++) begin
        m_act[i] = m_shd[i];
        m_shd[i] = m_act[i];
      end
      m_sel  = ~m_sel;
      m_pend = 1'b0;
    end
    check("bank_sel", 32'(bank_sel), 32'(m_sel));
  endtask

  // counts busy cycles while reading random addresses
  task automatic wait_idle(input string tag, input int exp_cycles);
    int n;
    logic [6:0] a;
    n = 0;
    while (busy && n < 500) begin
      a = 7'($urandom_range(0, 127));
      eq_coeff_addr = a;
      step();
      n++;
      check("busy_read", eq_coeff, exp_read(a));
    end
    check(tag, 32'(n), 32'(exp_cycles));
  endtask

  task automatic check_resets();
    check("rst_eq_coeff", eq_coeff, 32'h0);
    check("rst_wr_dr", 32'(s_wr_dr), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_bank_sel", 32'(bank_sel), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
  endtask

  initial begin
    logic [6:0] a;
    model_reset();
    #1;
    check_resets();
    step(); step();
    check_resets();
    rst_n = 1'b1;

    // 1: INIT duration and unity pattern
    wait_idle("init_cycles", 120);
    check("idle_wr_dr", 32'(s_wr_dr), 32'd1);
    read_chk(7'd0); check("unity_a0", eq_coeff, 32'h1000_0000);
    read_chk(7'd1); check("unity_a1", eq_coeff, 32'h0);
    read_chk(7'd5); check("unity_a5", eq_coeff, 32'h1000_0000);

    // 2: shadow write is invisible before commit
    do_write(7'd0, 32'h1800_0000);
    read_chk(7'd0); check("no_commit_a0", eq_coeff, 32'h1000_0000);

    // 3: commit, swap 50 clocks later, copy-back preserves addr0
    do_commit();
    check("pending_wr_dr", 32'(s_wr_dr), 32'd0);
    for (int i = 0; i < 49; i++) read_chk(7'd0);
    eq_coeff_addr = 7'd0;
    do_swap();
    read_chk(7'd0); check("after_swap_a0", eq_coeff, 32'h1800_0000);
    wait_idle("copy_cycles", 119);
    do_write(7'd1, 32'hCAFE_0001);
    do_commit();
    eq_coeff_addr = 7'd1;
    do_swap();
    read_chk(7'd1); check("second_a1", eq_coeff, 32'hCAFE_0001);
    wait_idle("copy_cycles2", 119);
    read_chk(7'd0); check("copy_kept_a0", eq_coeff, 32'h1800_0000);

    // 4: write and commit in one cycle, extra commit while pending
    s_wr_addr = 7'd7; s_wr_d = 32'h0ABC_DEF0; s_wr_dv = 1'b1; commit = 1'b1;
    step();
    s_wr_dv = 1'b0; commit = 1'b0;
    m_shd[7] = 32'h0ABC_DEF0; m_pend = 1'b1; m_err = 1'b0;
    read_chk(7'd7);
    do_commit();
    eq_coeff_addr = 7'd7;
    do_swap();
    read_chk(7'd7); check("wr_commit_a7", eq_coeff, 32'h0ABC_DEF0);
    wait_idle("copy_cycles3", 119);
    do_swap();
    check("idle_sync_busy", 32'(busy), 32'd0);

    // 5: out-of-range write
    do_write(7'd120, 32'hDEAD_BEEF);
    check("wr_err_set", 32'(wr_err), 32'd1);
    read_chk(7'd120);
    do_commit();
    check("wr_err_clr", 32'(wr_err), 32'd0);
    do_swap();
    wait_idle("copy_cycles4", 120);

    // randomized rounds of partial updates
    for (int r = 0; r < 8; r++) begin
      int nw;
      nw = $urandom_range(1, 8);
      for (int w = 0; w < nw; w++) begin
        a = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(120, 127)) : 7'($urandom_range(0, 119));
        do_write(a, $urandom);
        check("rnd_wr_err", 32'(wr_err), 32'(m_err));
      end
      do_commit();
      check("rnd_wr_err_clr", 32'(wr_err), 32'(m_err));
      for (int k = 0; k < int'($urandom_range(0, 10)); k++) read_chk(7'($urandom_range(0, 127)));
      if (r % 2 == 1) do_commit();
      eq_coeff_addr = 7'($urandom_range(0, 119));
      do_swap();
      read_chk(eq_coeff_addr);
      wait_idle("rnd_copy_cycles", 119);
    end
    for (int i = 0; i < 128; i++) read_chk(7'(i));

    // 6: reset in the middle of COPY
    do_write(7'd3, 32'h7777_0003);
    do_write(7'd10, 32'h1234_5678);
    do_commit();
    do_swap();
    for (int i = 0; i < 30; i++) step();
    #2 rst_n = 1'b0;
    #1 check_resets();
    step();
    check_resets();
    rst_n = 1'b1;
    model_reset();
    wait_idle("reinit_cycles", 120);
    for (int i = 0; i < 128; i++) read_chk(7'(i));
    check("reinit_bank_sel", 32'(bank_sel), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
